// File: rtl/spi_interface.sv
// spi_interface: IO-bus responder exposing a 4-register map and driving a
// single-select SPI master (modes 0-3, MSB first) on the physical pins.
// Optional build macro SPI_FRAME32_EN adds 8/16/32-bit frame selection via
// CTRL[13:12]; without it every frame is 8 bits and those bits read 0.
// The transfer-complete interrupt pin is named intr because "int" is a
// reserved word in SystemVerilog.
//
// state  | meaning
// IDLE   | CS_N high, SCLK parked at CPOL, waiting for a TXDATA write
// ASSERT | CS_N low for one half-period, first MOSI bit set up
// SHIFT  | SCLK toggles each half-period, 2*len toggles in total
// HOLD   | CS_N still low for one half-period, then completion
module spi_interface #(
    parameter logic [7:0] DIV_RST = 8'd13
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] data_io,
    input  logic        cs_en,
    input  logic        wt_en,
    input  logic        rd_en,
    input  logic [3:0]  addr_in,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CS_N,
    output logic        intr
);

    typedef enum logic [1:0] {IDLE, ASSERT, SHIFT, HOLD} state_t;

    state_t      state;
    logic [7:0]  div;
    logic        cpol;
    logic        cpha;
    logic        ie;
    logic [7:0]  cnt;
    logic [7:0]  edge_cnt;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic [31:0] rxdata;
    logic        rx_valid;
    logic        overrun;
    logic [31:0] rdata;
    logic [31:0] tx_load;
    logic [7:0]  last_edge;
    logic [6:0]  len;
    logic        wr;
    logic        rd;
    logic        busy;
    logic        lead;

`ifdef SPI_FRAME32_EN
    logic [1:0]  frame;

    // Frame length in bits from CTRL[13:12]; the reserved code falls back to 8
    always_comb begin
        case (frame)
            2'b01:   len = 7'd16;
            2'b10:   len = 7'd32;
            default: len = 7'd8;
        endcase
    end
`else
    assign len = 7'd8;
`endif

    assign wr        = cs_en & wt_en;
    assign rd        = cs_en & rd_en;
    assign busy      = (state != IDLE);
    // Left-justify the frame so MOSI always leaves from bit 31
    assign tx_load   = data_io << (7'd32 - len);
    assign last_edge = {len, 1'b0} - 8'd1;
    // Toggle number edge_cnt+1 is a leading edge when it is odd
    assign lead      = ~edge_cnt[0];

    // Read mux for the addressed register; unmapped addresses return 0
    always_comb begin
        rdata = '0;
        case (addr_in)
            4'd0: begin
                rdata[7:0] = div;
                rdata[8]   = cpol;
                rdata[9]   = cpha;
                rdata[10]  = ie;
`ifdef SPI_FRAME32_EN
                rdata[13:12] = frame;
`endif
            end
            4'd2:    rdata = rxdata;
            4'd3:    rdata = {29'd0, overrun, rx_valid, busy};
            default: rdata = '0;
        endcase
    end

    assign data_io = rd ? rdata : 32'bz;

    // Register file plus transfer FSM; later assignments give set-over-clear priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= DIV_RST;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            ie       <= 1'b0;
`ifdef SPI_FRAME32_EN
            frame    <= 2'b00;
`endif
            cnt      <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rxdata   <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            CS_N     <= 1'b1;
            intr     <= 1'b0;
        end else begin
            intr <= 1'b0;

            if (wr && addr_in == 4'd0 && !busy) begin
                div  <= data_io[7:0];
                cpol <= data_io[8];
                cpha <= data_io[9];
                ie   <= data_io[10];
`ifdef SPI_FRAME32_EN
                frame <= data_io[13:12];
`endif
            end
            if (rd && addr_in == 4'd2)
                rx_valid <= 1'b0;
            if (wr && addr_in == 4'd3 && data_io[2])
                overrun <= 1'b0;
            if (wr && addr_in == 4'd1 && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    SCLK <= cpol;
                    CS_N <= 1'b1;
                    if (wr && addr_in == 4'd1) begin
                        state    <= ASSERT;
                        CS_N     <= 1'b0;
                        cnt      <= div;
                        edge_cnt <= '0;
                        MOSI     <= tx_load[31];
                        tx_shift <= tx_load << 1;
                        rx_shift <= '0;
                    end
                end
                ASSERT: begin
                    if (cnt == 8'd0) begin
                        state <= SHIFT;
                        cnt   <= div;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == 8'd0) begin
                        cnt      <= div;
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + 8'd1;
                        if (lead ^ cpha) begin
                            rx_shift <= {rx_shift[30:0], MISO};
                        end else if (!(cpha && edge_cnt == 8'd0)) begin
                            // CPHA=1 already presented the MSB during ASSERT
                            MOSI     <= tx_shift[31];
                            tx_shift <= tx_shift << 1;
                        end
                        if (edge_cnt == last_edge)
                            state <= HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state    <= IDLE;
                        CS_N     <= 1'b1;
                        rxdata   <= rx_shift;
                        rx_valid <= 1'b1;
                        intr     <= ie;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_interface.sv
// Testbench for spi_interface: directed and randomized transfers against a
// behavioural SPI slave that shifts its own byte out and captures MOSI.
module tb_spi_interface;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] data_io;
    logic [31:0] drv;
    logic        drv_en;
    logic        cs_en;
    logic        wt_en;
    logic        rd_en;
    logic [3:0]  addr_in;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        CS_N;
    logic        intr;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave model state
    logic       loop_m;
    logic       s_out;
    logic       m_cpol;
    logic       m_cpha;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    int         s_drv;
    int         s_rise;

    assign data_io = drv_en ? drv : 32'bz;
    assign MISO    = loop_m ? MOSI : s_out;

    always #5 clk = ~clk;

    spi_interface dut (
        .clk     (clk),
        .rst     (rst),
        .data_io (data_io),
        .cs_en   (cs_en),
        .wt_en   (wt_en),
        .rd_en   (rd_en),
        .addr_in (addr_in),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .CS_N    (CS_N),
        .intr    (intr)
    );

    // Slave: select starts a frame; CPHA=0 presents MSB on select
    always @(negedge CS_N) begin
        s_rx   = 8'd0;
        s_rise = 0;
        if (!m_cpha) begin
            s_out = s_tx[7];
            s_drv = 1;
        end else begin
            s_drv = 0;
        end
    end

    // Slave: capture on the sampling edge, present next bit on the other edge
    always @(SCLK) begin
        if (CS_N === 1'b0) begin
            if (SCLK === 1'b1) s_rise++;
            if ((SCLK !== m_cpol) ^ m_cpha) begin
                s_rx = {s_rx[6:0], MOSI};
            end else if (s_drv < 8) begin
                s_out = s_tx[7 - s_drv];
                s_drv++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling clock edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        cs_en = 1'b1; wt_en = 1'b1; addr_in = a; drv = d; drv_en = 1'b1;
        @(negedge clk);
        cs_en = 1'b0; wt_en = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        cs_en = 1'b1; rd_en = 1'b1; addr_in = a;
        #1 d = data_io;
        @(negedge clk);
        cs_en = 1'b0; rd_en = 1'b0;
    endtask

    // One full transfer; act_* injects a single bus access on low-cycle act_at
    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] sbyte,
                        input logic [7:0] dv, input logic cpol, input logic cpha,
                        input logic ie, input logic lp, input int act_at,
                        input logic act_wr, input logic [3:0] act_addr,
                        input logic [31:0] act_data, input logic exp_ov);
        logic [31:0] ctrl;
        logic [31:0] r;
        logic [7:0]  exp_rx;
        int          cnt;
        ctrl   = {21'd0, ie, cpha, cpol, dv};
        m_cpol = cpol; m_cpha = cpha; s_tx = sbyte; loop_m = lp;
        bus_write(4'd0, ctrl);
        @(negedge clk);
        chk({tag, ":sclk_idle"}, SCLK, cpol);
        chk({tag, ":csn_idle"}, CS_N, 1'b1);
        bus_write(4'd1, {24'd0, tx});
        cnt = 0;
        while (CS_N === 1'b0 && cnt < 2000) begin
            cnt++;
            cs_en = 0; wt_en = 0; rd_en = 0; drv_en = 0;
            if (cnt == act_at) begin
                cs_en = 1'b1; addr_in = act_addr;
                if (act_wr) begin wt_en = 1'b1; drv = act_data; drv_en = 1'b1; end
                else rd_en = 1'b1;
            end
            @(negedge clk);
        end
        cs_en = 0; wt_en = 0; rd_en = 0; drv_en = 0;
        chk({tag, ":busy_cycles"}, cnt, 18 * (dv + 1));
        chk({tag, ":int_pulse"}, intr, ie);
        @(negedge clk);
        chk({tag, ":int_clear"}, intr, 1'b0);
        chk({tag, ":csn_after"}, CS_N, 1'b1);
        chk({tag, ":mosi_bits"}, s_rx, tx);
        chk({tag, ":sclk_rises"}, s_rise, 8);
        exp_rx = lp ? tx : sbyte;
        bus_read(4'd3, r);
        chk({tag, ":status_done"}, r, {29'd0, exp_ov, 1'b1, 1'b0});
        bus_read(4'd2, r);
        chk({tag, ":rxdata"}, r, {24'd0, exp_rx});
        bus_read(4'd3, r);
        chk({tag, ":status_read"}, r, {29'd0, exp_ov, 1'b0, 1'b0});
        bus_read(4'd0, r);
        chk({tag, ":ctrl_kept"}, r, ctrl);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; cs_en = 0; wt_en = 0; rd_en = 0; addr_in = 0; drv = 0; drv_en = 0;
        loop_m = 1'b1; s_out = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; s_tx = 8'd0;
        s_rx = 8'd0; s_drv = 0; s_rise = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_csn", CS_N, 1'b1);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_int", intr, 1'b0);
        bus_read(4'd0, r); chk("rst_ctrl", r, 32'h0000_000D);
        bus_read(4'd3, r); chk("rst_status", r, 32'h0);
        bus_read(4'd2, r); chk("rst_rxdata", r, 32'h0);

        // Unused bits and addresses
        bus_write(4'd0, 32'hFFFF_FFFF);
        bus_read(4'd0, r);
`ifdef SPI_FRAME32_EN
        chk("ctrl_mask", r, 32'h0000_37FF);
`else
        chk("ctrl_mask", r, 32'h0000_07FF);
`endif
        bus_write(4'd0, 32'h0000_000D);
        bus_write(4'd7, 32'hDEAD_BEEF);
        bus_read(4'd7, r); chk("unmapped_read", r, 32'h0);
        bus_read(4'd1, r); chk("txdata_read", r, 32'h0);
        chk("unmapped_no_start", CS_N, 1'b1);

        // Mode 0 loopback, DIV=1
        xfer("mode0", 8'hA5, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        // Mode 3 with slave sending 0x3C, DIV=0
        xfer("mode3", 8'h00, 8'h3C, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        // Overrun: second TXDATA while busy is dropped
        xfer("overrun", 8'h11, 8'h5A, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 4'd1, 32'h22, 1'b1);
        bus_write(4'd3, 32'h4);
        bus_read(4'd3, r); chk("overrun_w1c", r, 32'h0);
        // Interrupt, with a CTRL write while busy that must be ignored
        xfer("irq", 8'hC3, 8'h96, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b1, 4'd0, 32'h0FF, 1'b0);
        // TXDATA write on the completion edge is dropped and flags overrun
        xfer("tx_at_done", 8'h6E, 8'h81, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 18, 1'b1, 4'd1, 32'h77, 1'b1);
        bus_write(4'd3, 32'h4);
        bus_read(4'd3, r); chk("overrun_w1c2", r, 32'h0);
        // RXDATA read on the completion edge: set wins
        xfer("rd_at_done", 8'h3F, 8'hE4, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 36, 1'b0, 4'd2, 32'd0, 1'b0);

        // Reset mid-transfer
        bus_write(4'd0, 32'h0000_0003);
        bus_write(4'd1, 32'h0000_00F0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_csn", CS_N, 1'b1);
        chk("midrst_sclk", SCLK, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(4'd3, r); chk("midrst_status", r, 32'h0);
        bus_read(4'd0, r); chk("midrst_ctrl", r, 32'h0000_000D);
        xfer("after_rst", 8'h5C, 8'h2B, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, 32'd0, 1'b0);

        // Randomized transfers
        for (int i = 0; i < 6; i++) begin
            r  = $urandom;
            ra = $urandom;
            rb = $urandom_range(0, 3);
            xfer("rand", r[7:0], ra[7:0], rb[7:0], r[8], r[9], r[10], r[11],
                 0, 1'b0, 4'd0, 32'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
